sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised synchronous FIFO that replaces the fixed 8×32 FIFO buffer as the general-purpose single-clock queue in the datapath. Width, depth and almost-full/almost-empty thresholds are configurable. It supports simultaneous read and write, including at full, and exposes an occupancy count and one-cycle overflow/underflow error pulses. A FWFT parameter selects registered-read or first-word-fall-through output.

## Interface
- DATA_W, 32, word width in bits
- DEPTH, 8, number of entries; power of two, ≥ 2
- AF_THRESH, DEPTH-2, ALMOST_FULL asserts when COUNT ≥ AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 2, ALMOST_EMPTY asserts when COUNT ≤ AE_THRESH; legal range 0..DEPTH-1
- FWFT, 0, 0 = registered read, 1 = first-word-fall-through
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high; clock Clk
- EN  in  1  global enable; when 0, no pointer, count or data change
- WR  in  1  write request
- dataIn  in  DATA_W  write data
- RD  in  1  read request (FWFT=1: pop acknowledge)
- dataOut  out  DATA_W  read data
- COUNT  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- EMPTY, FULL  out  1  COUNT==0 / COUNT==DEPTH
- ALMOST_EMPTY, ALMOST_FULL  out  1  threshold flags
- OVERFLOW, UNDERFLOW  out  1  one-cycle error pulses

## Operation
- Storage: DEPTH×DATA_W array; rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. COUNT is a separate register.
- Rst has priority over EN. On reset:
  - rd_ptr = wr_ptr = COUNT = 0
  - dataOut = 0, OVERFLOW = UNDERFLOW = 0
  - Resulting flags: EMPTY = 1, FULL = 0, ALMOST_EMPTY = 1, ALMOST_FULL = 0 (if AF_THRESH ≥ 1)
  - Array contents are not cleared.
- Read is accepted when EN & RD & !EMPTY.
- Write is accepted when EN & WR & (!FULL | rd_acc). A write at full is accepted only when a read is accepted in the same cycle.
- Empty with RD & WR both high: read is rejected (UNDERFLOW pulse) and the write is accepted.
- COUNT update: +1 on write only, −1 on read only, unchanged when both or neither are accepted.
- OVERFLOW = 1 for one cycle after an edge where EN & WR was high and the write was rejected. UNDERFLOW is the same for EN & RD with a rejected read. Both pulses are 0 whenever EN = 0.
- Flags are combinational decodes of the registered COUNT, so they are glitch-free relative to Clk.
- FWFT=0: on an accepted read, dataOut <= mem[rd_ptr]. Otherwise dataOut holds its value.
- FWFT=1: dataOut = EMPTY ? 0 : mem[rd_ptr], combinational from registered state. RD consumes the displayed word.
- EN = 0: all state holds, and the error pulses are forced to 0 on the next edge.

## Timing
- Write at edge N: COUNT and the flags update after edge N. The word is poppable from cycle N+1.
- FWFT=0 read: data appears on dataOut after the accepting edge (1-cycle latency).
- FWFT=1 read: the head word is visible in the same cycle EMPTY is low. After the popping edge, dataOut shows the next word, or 0 if the FIFO is now empty.
- Minimum write-to-dataOut latency: 2 edges for FWFT=0, 1 edge for FWFT=1.
- Sustained throughput: one read and one write per cycle at any occupancy, subject to the full/empty rules above.
- Error pulses are registered and are high for exactly the cycle after the offending edge.

## Test plan
- Reset: assert Rst for 2 cycles with EN = 0 → COUNT = 0, EMPTY = 1, FULL = 0, ALMOST_EMPTY = 1, dataOut = 0, no error pulses.
- Fill and overflow (DEPTH=8, defaults): 8 writes of 0x1..0x8 → FULL = 1 and COUNT = 8; ALMOST_FULL rises after the 6th write. A 9th write of 0x9 → OVERFLOW pulses 1 cycle and COUNT stays 8. Draining 8 reads → 0x1..0x8 in order, and 0x9 never appears.
- Simultaneous at full: with 8 entries, RD = WR = 1 with dataIn = 0xA → read returns the oldest word, COUNT stays 8, no OVERFLOW, and 0xA is read last.
- Empty with RD & WR: RD = WR = 1, dataIn = 0x55 → UNDERFLOW pulses, COUNT = 1, and the next read returns 0x55.
- Wrap-around: run 20 write/read pairs at COUNT = 3 → pointers wrap at least twice, data order is preserved, and COUNT stays 3.
- FWFT=1 and EN: write 0x11 → dataOut = 0x11 one edge later with no RD. Hold EN = 0 with RD/WR toggling → no change in COUNT or dataOut. Set EN = 1 and RD → dataOut = 0 and EMPTY = 1.

Source files
------------

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO. Supports simultaneous read and write at any
//   occupancy, including a write at full when a read is accepted in the same
//   cycle. Exposes an occupancy count, threshold flags and one-cycle
//   overflow/underflow pulses. FWFT selects the read mode:
//     FWFT = 0 : registered read, dataOut updates on the accepting edge
//     FWFT = 1 : first-word-fall-through, dataOut shows the head word (0 when empty)
//
// Ports
//   Clk           clock, all state updates on the rising edge
//   Rst           synchronous active-high reset (takes priority over EN)
//   EN            global enable; when low, no state changes
//   WR / dataIn   write request and write data
//   RD            read request (pop acknowledge in FWFT mode)
//   dataOut       read data
//   COUNT         occupancy, 0..DEPTH
//   EMPTY / FULL  COUNT == 0 / COUNT == DEPTH
//   ALMOST_EMPTY  COUNT <= AE_THRESH
//   ALMOST_FULL   COUNT >= AF_THRESH
//   OVERFLOW      high for the cycle after a rejected write
//   UNDERFLOW     high for the cycle after a rejected read
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     EN,
    input  logic                     WR,
    input  logic [DATA_W-1:0]        dataIn,
    input  logic                     RD,
    output logic [DATA_W-1:0]        dataOut,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     ALMOST_EMPTY,
    output logic                     ALMOST_FULL,
    output logic                     OVERFLOW,
    output logic                     UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          empty_s, full_s;
    logic          rd_acc_s, wr_acc_s;

    // Acceptance decode; a write at full rides on a same-cycle accepted read.
    always_comb begin
        empty_s  = (count_q == {CW{1'b0}});
        full_s   = (count_q == CW'(DEPTH));
        rd_acc_s = EN & RD & ~empty_s;
        wr_acc_s = EN & WR & (~full_s | rd_acc_s);
    end

    // Next-state for pointers, occupancy and error pulses.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);   // power-of-two depth: wraps naturally
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Requests without EN never count as rejected, so pulses clear when EN=0.
        ovf_d = EN & WR & ~wr_acc_s;
        unf_d = EN & RD & ~rd_acc_s;
    end

    // Control state registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array; contents survive reset, writes are blocked while in reset.
    always_ff @(posedge Clk) begin
        if (!Rst && wr_acc_s) begin
            mem_q[wr_ptr_q] <= dataIn;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word falls through; forced to zero when there is no head.
            always_comb begin
                if (empty_s) begin
                    dataOut = {DATA_W{1'b0}};
                end else begin
                    dataOut = mem_q[rd_ptr_q];
                end
            end
        end else begin : g_reg
            logic [DATA_W-1:0] dout_q;
            // Registered read port, loads only on an accepted read.
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    dout_q <= {DATA_W{1'b0}};
                end else if (rd_acc_s) begin
                    dout_q <= mem_q[rd_ptr_q];
                end else begin
                    dout_q <= dout_q;
                end
            end
            assign dataOut = dout_q;
        end
    endgenerate

    // Flags decode the registered count only, so they cannot glitch mid-cycle.
    assign COUNT        = count_q;
    assign EMPTY        = empty_s;
    assign FULL         = full_s;
    assign ALMOST_EMPTY = (count_q <= CW'(AE_THRESH));
    assign ALMOST_FULL  = (count_q >= CW'(AF_THRESH));
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//   Drives a registered-read FIFO and a FWFT FIFO with identical stimulus and
//   checks both, every cycle, against a queue-based reference. Directed
//   sequences add literal expectations; a randomised phase follows.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          EN  = 1'b0;
    logic          WR  = 1'b0;
    logic          RD  = 1'b0;
    logic [DW-1:0] dataIn = 32'h0;

    logic [DW-1:0] dout0, dout1;
    logic [3:0]    cnt0, cnt1;
    logic          emp0, emp1, ful0, ful1, ae0, ae1, af0, af1;
    logic          ovf0, ovf1, unf0, unf1;

    always #5 Clk = ~Clk;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) u_reg (
        .Clk(Clk), .Rst(Rst), .EN(EN), .WR(WR), .dataIn(dataIn), .RD(RD),
        .dataOut(dout0), .COUNT(cnt0), .EMPTY(emp0), .FULL(ful0),
        .ALMOST_EMPTY(ae0), .ALMOST_FULL(af0), .OVERFLOW(ovf0), .UNDERFLOW(unf0)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .Clk(Clk), .Rst(Rst), .EN(EN), .WR(WR), .dataIn(dataIn), .RD(RD),
        .dataOut(dout1), .COUNT(cnt1), .EMPTY(emp1), .FULL(ful1),
        .ALMOST_EMPTY(ae1), .ALMOST_FULL(af1), .OVERFLOW(ovf1), .UNDERFLOW(unf1)
    );

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout_reg = 32'h0;
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;
    bit            chk_en  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the reference by one clock edge using the inputs that were held.
    task automatic model_step();
        bit rd_ok, wr_ok;
        if (Rst) begin
            q.delete();
            exp_dout_reg = 32'h0;
            exp_ovf      = 1'b0;
            exp_unf      = 1'b0;
        end else if (!EN) begin
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            rd_ok = RD && (q.size() > 0);
            wr_ok = WR && ((q.size() < DEPTH) || rd_ok);
            if (rd_ok) exp_dout_reg = q.pop_front();
            if (wr_ok) q.push_back(dataIn);
            exp_ovf = WR && !wr_ok;
            exp_unf = RD && !rd_ok;
        end
    endtask

    // Apply inputs for one cycle, then step the model past the edge.
    task automatic cycle(input bit rst, input bit en, input bit wr, input bit rd,
                         input logic [31:0] din);
        Rst    = rst;
        EN     = en;
        WR     = wr;
        RD     = rd;
        dataIn = din;
        @(posedge Clk);
        #1;
        model_step();
        chk_en = 1'b1;
    endtask

    // Per-cycle comparison of both DUTs against the model.
    initial begin
        int sz;
        logic [31:0] head;
        forever begin
            @(negedge Clk);
            if (chk_en) begin
                sz   = q.size();
                head = (sz > 0) ? q[0] : 32'h0;
                chk("reg_count",  32'(cnt0), 32'(sz));
                chk("reg_empty",  32'(emp0), 32'(sz == 0));
                chk("reg_full",   32'(ful0), 32'(sz == DEPTH));
                chk("reg_ae",     32'(ae0),  32'(sz <= AE));
                chk("reg_af",     32'(af0),  32'(sz >= AF));
                chk("reg_ovf",    32'(ovf0), 32'(exp_ovf));
                chk("reg_unf",    32'(unf0), 32'(exp_unf));
                chk("reg_dout",   dout0,     exp_dout_reg);
                chk("fwft_count", 32'(cnt1), 32'(sz));
                chk("fwft_empty", 32'(emp1), 32'(sz == 0));
                chk("fwft_full",  32'(ful1), 32'(sz == DEPTH));
                chk("fwft_ae",    32'(ae1),  32'(sz <= AE));
                chk("fwft_af",    32'(af1),  32'(sz >= AF));
                chk("fwft_ovf",   32'(ovf1), 32'(exp_ovf));
                chk("fwft_unf",   32'(unf1), 32'(exp_unf));
                chk("fwft_dout",  dout1,     head);
            end
        end
    end

    initial begin
        // Reset for two cycles with EN low
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_count", 32'(cnt0), 32'd0);
        chk("rst_empty", 32'(emp0), 32'd1);
        chk("rst_full",  32'(ful0), 32'd0);
        chk("rst_ae",    32'(ae0),  32'd1);
        chk("rst_af",    32'(af0),  32'd0);
        chk("rst_dout",  dout0,     32'h0);
        chk("rst_dout_fwft", dout1, 32'h0);
        chk("rst_pulses", 32'({ovf0, unf0}), 32'd0);

        // Fill with 1..8; ALMOST_FULL rises after the 6th write
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'(i));
            if (i == 5) chk("af_before_6th", 32'(af0), 32'd0);
            if (i == 6) chk("af_after_6th",  32'(af0), 32'd1);
        end
        chk("fill_full",  32'(ful0), 32'd1);
        chk("fill_count", 32'(cnt0), 32'd8);
        chk("fwft_head_full", dout1, 32'h1);

        // Rejected 9th write
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h9);
        chk("ovf_pulse",  32'(ovf0), 32'd1);
        chk("ovf_count",  32'(cnt0), 32'd8);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("ovf_clear",  32'(ovf0), 32'd0);

        // Simultaneous read/write at full
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hA);
        chk("full_rw_dout",  dout0, 32'h1);
        chk("full_rw_count", 32'(cnt0), 32'd8);
        chk("full_rw_ovf",   32'(ovf0), 32'd0);

        // Drain: 2..8 then 0xA; 0x9 never appears
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
            chk("drain_dout", dout0, (i < 7) ? 32'(i + 2) : 32'hA);
        end
        chk("drain_empty", 32'(emp0), 32'd1);

        // Empty with RD & WR: read rejected, write accepted
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h55);
        chk("empty_rw_unf",   32'(unf0), 32'd1);
        chk("empty_rw_count", 32'(cnt0), 32'd1);
        chk("empty_rw_fwft",  dout1,     32'h55);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        chk("empty_rw_read",  dout0,     32'h55);

        // Wrap-around: hold COUNT at 3 over 20 write/read pairs
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'(32'h100 + i));
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'(32'h103 + i));
            chk("wrap_dout",  dout0,     32'(32'h100 + i));
            chk("wrap_count", 32'(cnt0), 32'd3);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        chk("wrap_tail", dout0, 32'h116);

        // FWFT fall-through and EN hold
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h11);
        chk("fwft_fall", dout1, 32'h11);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, i[0], ~i[0], 32'(32'hDEAD + i));
            chk("en0_count", 32'(cnt1), 32'd1);
            chk("en0_dout",  dout1,     32'h11);
            chk("en0_pulse", 32'({ovf1, unf1}), 32'd0);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        chk("fwft_pop_dout",  dout1,     32'h0);
        chk("fwft_pop_empty", 32'(emp1), 32'd1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1),
                  $urandom());
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge Clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
